ex_mem_redirect: RTL

//  EX/MEM pipeline register for the 5-stage MIPS core. It registers the EX-stage result and the

---
 rtl/ex_mem_redirect_if.sv | 67 ++++++
 rtl/ex_mem_redirect.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ex_mem_redirect_if.sv
// EX -> MEM bus for the EX/MEM redirect register.
// Optional BRANCH_STATS_EN adds the taken-branch / jump counters.
interface ex_mem_redirect_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned RAW = 5
`ifdef BRANCH_STATS_EN
  , parameter int unsigned CNTW = 32
`endif
);
  // EX-side controls and datapath
  logic           stall;
  logic           IE_MemtoReg;
  logic           IE_MemWrite;
  logic           IE_MemRead;
  logic           IE_RegWrite;
  logic           IE_Branch_bne;
  logic           IE_Branch_bgtz;
  logic [1:0]     IE_jump;
  logic [DW-1:0]  IE_PCPlus4;
  logic [25:0]    IE_JAddr;
  logic [DW-1:0]  IE_SignImm;
  logic [DW-1:0]  IE_RegData1;
  logic [DW-1:0]  IE_RegData2;
  logic [DW-1:0]  ALUResult;
  logic           ALUZero;
  logic [RAW-1:0] WriteReg;

  // Registered MEM-stage view
  logic           EM_MemtoReg;
  logic           EM_MemWrite;
  logic           EM_MemRead;
  logic           EM_RegWrite;
  logic [RAW-1:0] EM_WriteReg;
  logic [DW-1:0]  EM_ALUResult;
  logic [DW-1:0]  EM_WriteData;
  logic           EM_PCSrc;
  logic [1:0]     EM_jump;
  logic [DW-1:0]  EM_PCTarget;
`ifdef BRANCH_STATS_EN
  logic [CNTW-1:0] EM_TakenCnt;
  logic [CNTW-1:0] EM_JumpCnt;
`endif

  // EX stage drives the inputs and observes the registered outputs
  modport master (
    output stall, IE_MemtoReg, IE_MemWrite, IE_MemRead, IE_RegWrite,
           IE_Branch_bne, IE_Branch_bgtz, IE_jump, IE_PCPlus4, IE_JAddr,
           IE_SignImm, IE_RegData1, IE_RegData2, ALUResult, ALUZero, WriteReg,
    input  EM_MemtoReg, EM_MemWrite, EM_MemRead, EM_RegWrite, EM_WriteReg,
           EM_ALUResult, EM_WriteData, EM_PCSrc, EM_jump, EM_PCTarget
`ifdef BRANCH_STATS_EN
    , input EM_TakenCnt, EM_JumpCnt
`endif
  );

  // The pipeline register itself
  modport slave (
    input  stall, IE_MemtoReg, IE_MemWrite, IE_MemRead, IE_RegWrite,
           IE_Branch_bne, IE_Branch_bgtz, IE_jump, IE_PCPlus4, IE_JAddr,
           IE_SignImm, IE_RegData1, IE_RegData2, ALUResult, ALUZero, WriteReg,
    output EM_MemtoReg, EM_MemWrite, EM_MemRead, EM_RegWrite, EM_WriteReg,
           EM_ALUResult, EM_WriteData, EM_PCSrc, EM_jump, EM_PCTarget
`ifdef BRANCH_STATS_EN
    , output EM_TakenCnt, EM_JumpCnt
`endif
  );
endinterface

// File: rtl/ex_mem_redirect.sv
// EX/MEM pipeline register with branch/jump resolution and one-cycle
// redirect squash. Define BRANCH_STATS_EN to add saturating counters
// for taken branches and jumps.
module ex_mem_redirect #(
  parameter int unsigned DW  = 32,
  parameter int unsigned RAW = 5
`ifdef BRANCH_STATS_EN
  , parameter int unsigned CNTW = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_mem_redirect_if.slave   bus
);

  localparam logic [1:0] JMP_NONE = 2'd0;
  localparam logic [1:0] JMP_J    = 2'd1;
  localparam logic [1:0] JMP_JR   = 2'd2;
  localparam logic [1:0] JMP_RSVD = 2'd3;

  logic           r_memtoreg;
  logic           r_memwrite;
  logic           r_memread;
  logic           r_regwrite;
  logic [RAW-1:0] r_writereg;
  logic [DW-1:0]  r_aluresult;
  logic [DW-1:0]  r_writedata;
  logic           r_pcsrc;
  logic [1:0]     r_jump;
  logic [DW-1:0]  r_pctarget;

  logic           w_redirect;
  logic           w_taken_bne;
  logic           w_taken_bgtz;
  logic           w_pcsrc_ld;
  logic [1:0]     w_jump_ld;
  logic [DW-1:0]  w_target;
  logic           w_load;

  // Redirect in flight: the instruction now in EX is on the wrong path
  assign w_redirect = r_pcsrc | (r_jump == JMP_J) | (r_jump == JMP_JR);
  assign w_load     = ~bus.stall & ~w_redirect;

  // Branch resolution; bgtz is a signed strictly-positive test on rs
  assign w_taken_bne  = bus.IE_Branch_bne & ~bus.ALUZero;
  assign w_taken_bgtz = bus.IE_Branch_bgtz & ~bus.IE_RegData1[DW-1] & (|bus.IE_RegData1);
  assign w_pcsrc_ld   = w_taken_bne | w_taken_bgtz;
  assign w_jump_ld    = (bus.IE_jump == JMP_RSVD) ? JMP_NONE : bus.IE_jump;

  // Redirect target; a jump code overrides the branch adder
  always_comb begin
    w_target = bus.IE_PCPlus4 + (bus.IE_SignImm << 2);
    case (bus.IE_jump)
      JMP_J:   w_target = {bus.IE_PCPlus4[DW-1:28], bus.IE_JAddr, 2'b00};
      JMP_JR:  w_target = bus.IE_RegData1;
      default: w_target = bus.IE_PCPlus4 + (bus.IE_SignImm << 2);
    endcase
  end

  // Pipeline register: stall holds, redirect squashes side-effecting controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memtoreg  <= 1'b0;
      r_memwrite  <= 1'b0;
      r_memread   <= 1'b0;
      r_regwrite  <= 1'b0;
      r_writereg  <= '0;
      r_aluresult <= '0;
      r_writedata <= '0;
      r_pcsrc     <= 1'b0;
      r_jump      <= JMP_NONE;
      r_pctarget  <= '0;
    end else if (!bus.stall) begin
      r_memtoreg  <= bus.IE_MemtoReg;
      r_writereg  <= bus.WriteReg;
      r_aluresult <= bus.ALUResult;
      r_writedata <= bus.IE_RegData2;
      r_pctarget  <= w_target;
      if (w_redirect) begin
        r_memwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_regwrite <= 1'b0;
        r_pcsrc    <= 1'b0;
        r_jump     <= JMP_NONE;
      end else begin
        r_memwrite <= bus.IE_MemWrite;
        r_memread  <= bus.IE_MemRead;
        r_regwrite <= bus.IE_RegWrite;
        r_pcsrc    <= w_pcsrc_ld;
        r_jump     <= w_jump_ld;
      end
    end
  end

  assign bus.EM_MemtoReg  = r_memtoreg;
  assign bus.EM_MemWrite  = r_memwrite;
  assign bus.EM_MemRead   = r_memread;
  assign bus.EM_RegWrite  = r_regwrite;
  assign bus.EM_WriteReg  = r_writereg;
  assign bus.EM_ALUResult = r_aluresult;
  assign bus.EM_WriteData = r_writedata;
  assign bus.EM_PCSrc     = r_pcsrc;
  assign bus.EM_jump      = r_jump;
  assign bus.EM_PCTarget  = r_pctarget;

`ifdef BRANCH_STATS_EN
  logic [CNTW-1:0] r_taken_cnt;
  logic [CNTW-1:0] r_jump_cnt;
  logic            w_jump_taken;

  assign w_jump_taken = (w_jump_ld == JMP_J) | (w_jump_ld == JMP_JR);

  // Saturating counters, advanced only on real (non-squashed) loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken_cnt <= '0;
      r_jump_cnt  <= '0;
    end else if (w_load) begin
      if (w_pcsrc_ld && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + CNTW'(1);
      if (w_jump_taken && (r_jump_cnt != '1))
        r_jump_cnt <= r_jump_cnt + CNTW'(1);
    end
  end

  assign bus.EM_TakenCnt = r_taken_cnt;
  assign bus.EM_JumpCnt  = r_jump_cnt;
`endif

endmodule
